ni_flit_injector: RTL and testbench

Network-interface transmitter that turns packet requests from the local processing element into `flit_t` flit streams for the router's local input port. It drives the same flits the router's input buffer and `rc_unit` consume: head flits carry `x_dest`/`y_dest`, and it tags flits HEAD/BODY/TAIL/HEADTAIL with a VC id. It meters injection with per-VC credit counters mirroring the router input buffers.

---
 rtl/ni_flit_injector_if.sv | 52 +++++
 rtl/ni_flit_injector.sv | 116 +++++++++++
 tb/tb_ni_flit_injector.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ni_flit_injector_if.sv
// ni_flit_injector_if: flit format package and the PE/router-facing bundle of the flit injector.
package ni_flit_pkg;
  localparam int FLIT_X_W = 3;
  localparam int FLIT_Y_W = 3;
  localparam int FLIT_VC_W = 1;
  localparam int FLIT_DATA_W = 32;
  localparam logic [1:0] FT_HEAD = 2'd0, FT_BODY = 2'd1, FT_TAIL = 2'd2, FT_HEADTAIL = 2'd3;
  typedef struct packed {
    logic [1:0] flit_label;
    logic [FLIT_VC_W-1:0] vc_id;
    logic [FLIT_X_W-1:0] x_dest;
    logic [FLIT_Y_W-1:0] y_dest;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;
endpackage

interface ni_flit_injector_if #(
  parameter int MESH_SIZE_X = 5,
  parameter int MESH_SIZE_Y = 5,
  parameter int VC_NUM = 2,
  parameter int MAX_PKT_LEN = 8
);
  localparam int XW = $clog2(MESH_SIZE_X);
  localparam int YW = $clog2(MESH_SIZE_Y);
  localparam int LW = $clog2(MAX_PKT_LEN) + 1;
  localparam int VW = $clog2(VC_NUM);
  logic pkt_valid_i;
  logic pkt_ready_o;
  logic [XW-1:0] pkt_x_dest_i;
  logic [YW-1:0] pkt_y_dest_i;
  logic [LW-1:0] pkt_len_i;
  logic [VW-1:0] pkt_vc_i;
  logic payload_valid_i;
  logic payload_ready_o;
  logic [ni_flit_pkg::FLIT_DATA_W-1:0] payload_i;
  ni_flit_pkg::flit_t flit_o;
  logic valid_flit_o;
  logic credit_valid_i;
  logic [VW-1:0] credit_vc_i;
  logic drop_o;
  logic credit_err_o;
  modport slave (
    input pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i, pkt_len_i, pkt_vc_i,
    input payload_valid_i, payload_i, credit_valid_i, credit_vc_i,
    output pkt_ready_o, payload_ready_o, flit_o, valid_flit_o, drop_o, credit_err_o
  );
  modport master (
    output pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i, pkt_len_i, pkt_vc_i,
    output payload_valid_i, payload_i, credit_valid_i, credit_vc_i,
    input pkt_ready_o, payload_ready_o, flit_o, valid_flit_o, drop_o, credit_err_o
  );
endinterface

// File: rtl/ni_flit_injector.sv
// ni_flit_injector: packet requests to credit-metered HEAD/BODY/TAIL flit streams for the local router port.
// Optional NI_PKT_COUNT_EN adds pkts_sent_o/flits_sent_o statistics counters.
module ni_flit_injector #(
  parameter int X_CURRENT = 2,
  parameter int Y_CURRENT = 2,
  parameter int MESH_SIZE_X = 5,
  parameter int MESH_SIZE_Y = 5,
  parameter int VC_NUM = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int MAX_PKT_LEN = 8
) (
  input logic clk,
  input logic rst,
  ni_flit_injector_if.slave bus
`ifdef NI_PKT_COUNT_EN
  ,
  output logic [15:0] pkts_sent_o,
  output logic [15:0] flits_sent_o
`endif
);
  import ni_flit_pkg::*;
  localparam logic [1:0] IDLE = 2'd0, HEAD = 2'd1, BODY = 2'd2;
  localparam int XW = $clog2(MESH_SIZE_X);
  localparam int YW = $clog2(MESH_SIZE_Y);
  localparam int LW = $clog2(MAX_PKT_LEN) + 1;
  localparam int VW = $clog2(VC_NUM);
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);
  localparam logic [LW-1:0] ONE = LW'(1);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT_LEN);
  if (X_CURRENT >= MESH_SIZE_X || Y_CURRENT >= MESH_SIZE_Y) begin : g_bad_coord
    $error("node coordinate outside the mesh");
  end
  logic [1:0] state;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [LW-1:0] len_q, rem_q, len_in;
  logic [VW-1:0] vc_q;
  logic [VC_NUM-1:0][CW-1:0] credit, credit_d;
  logic [VC_NUM-1:0] snd, rtn;
  logic accept, dest_ok, avail, send, last, err_hit, valid_q, drop_q, err_q;
  flit_t flit_d, flit_q;
  always_comb begin
    len_in = bus.pkt_len_i == '0 ? ONE : bus.pkt_len_i > MAX_LEN ? MAX_LEN : bus.pkt_len_i;
    dest_ok = int'(bus.pkt_x_dest_i) < MESH_SIZE_X && int'(bus.pkt_y_dest_i) < MESH_SIZE_Y;
    accept = bus.pkt_valid_i && state == IDLE;
    // a credit arriving on this edge may fund the send decided on the same edge
    avail = credit[vc_q] != '0 || (bus.credit_valid_i && bus.credit_vc_i == vc_q);
    send = avail && (state == HEAD || (state == BODY && bus.payload_valid_i));
    last = state == HEAD ? len_q == ONE : rem_q == ONE;
    flit_d = '0;
    flit_d.flit_label = state == HEAD ? (last ? FT_HEADTAIL : FT_HEAD) : (last ? FT_TAIL : FT_BODY);
    flit_d.vc_id = vc_q;
    flit_d.x_dest = state == HEAD ? x_q : '0;
    flit_d.y_dest = state == HEAD ? y_q : '0;
    flit_d.data = state == HEAD ? '0 : bus.payload_i;
    snd = '0;
    rtn = '0;
    credit_d = credit;
    err_hit = 1'b0;
    // a return at full is only legal when a send on that VC frees a slot this cycle
    for (int v = 0; v < VC_NUM; v++) begin
      snd[v] = send && vc_q == VW'(v);
      rtn[v] = bus.credit_valid_i && bus.credit_vc_i == VW'(v) && (credit[v] != FULL || snd[v]);
      credit_d[v] = credit[v] - CW'(snd[v]) + CW'(rtn[v]);
      err_hit = err_hit | (bus.credit_valid_i && bus.credit_vc_i == VW'(v) && !rtn[v]);
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      x_q <= '0;
      y_q <= '0;
      len_q <= '0;
      rem_q <= '0;
      vc_q <= '0;
      credit <= {VC_NUM{FULL}};
      flit_q <= '0;
      valid_q <= 1'b0;
      drop_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      valid_q <= send;
      flit_q <= send ? flit_d : '0;
      drop_q <= accept && !dest_ok;
      err_q <= err_q | err_hit;
      credit <= credit_d;
      if (accept && dest_ok) begin
        x_q <= bus.pkt_x_dest_i;
        y_q <= bus.pkt_y_dest_i;
        len_q <= len_in;
        vc_q <= bus.pkt_vc_i;
        state <= HEAD;
      end
      if (send) begin
        rem_q <= (state == HEAD ? len_q : rem_q) - ONE;
        state <= last ? IDLE : BODY;
      end
    end
  assign bus.pkt_ready_o = state == IDLE;
  assign bus.payload_ready_o = state == BODY && avail;
  assign bus.flit_o = flit_q;
  assign bus.valid_flit_o = valid_q;
  assign bus.drop_o = drop_q;
  assign bus.credit_err_o = err_q;
`ifdef NI_PKT_COUNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pkts_sent_o <= '0;
      flits_sent_o <= '0;
    end else begin
      pkts_sent_o <= pkts_sent_o + 16'(send && last);
      flits_sent_o <= flits_sent_o + 16'(send);
    end
`endif
endmodule

// File: tb/tb_ni_flit_injector.sv
// tb_ni_flit_injector: table of packet requests checked through a flit scoreboard, plus credit/reset corner sequences.
module tb_ni_flit_injector;
  import ni_flit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  ni_flit_injector_if bus ();
`ifdef NI_PKT_COUNT_EN
  logic [15:0] pkts_sent, flits_sent;
  ni_flit_injector dut (.clk(clk), .rst(rst), .bus(bus), .pkts_sent_o(pkts_sent), .flits_sent_o(flits_sent));
`else
  ni_flit_injector dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  typedef struct {
    logic [2:0] x;
    logic [2:0] y;
    logic [3:0] len;
    logic vc;
    logic [31:0] base;
    logic exp_drop;
    int exp_n;
  } vec_t;
  vec_t tv[9];
  flit_t exp_q[$];
  int errs = 0;
  int checks = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic flit_t mk_flit(input int i, input int n, input logic [2:0] x, input logic [2:0] y,
                                    input logic vc, input logic [31:0] data);
    flit_t f;
    f = '0;
    f.vc_id = vc;
    if (i == 0) begin
      f.flit_label = n == 1 ? FT_HEADTAIL : FT_HEAD;
      f.x_dest = x;
      f.y_dest = y;
    end else begin
      f.flit_label = i == n - 1 ? FT_TAIL : FT_BODY;
      f.data = data;
    end
    return f;
  endfunction
  always @(negedge clk)
    if (rst && bus.valid_flit_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected flit: got %h expected none", bus.flit_o);
      end else check("flit", bus.flit_o, exp_q.pop_front());
    end
  task automatic send_pkt(input logic [2:0] x, input logic [2:0] y, input logic [3:0] len, input logic vc,
                          input logic [31:0] base, input logic drop, input int n, input bit feed);
    int w;
    if (!drop) for (int i = 0; i < n; i++) exp_q.push_back(mk_flit(i, n, x, y, vc, base + 32'(i) - 1));
    @(negedge clk);
    w = 0;
    while (!bus.pkt_ready_o && w < 100) begin @(negedge clk); w++; end
    check("pkt_ready before request", bus.pkt_ready_o, 1);
    bus.pkt_valid_i = 1'b1;
    bus.pkt_x_dest_i = x;
    bus.pkt_y_dest_i = y;
    bus.pkt_len_i = len;
    bus.pkt_vc_i = vc;
    @(negedge clk);
    bus.pkt_valid_i = 1'b0;
    check("drop_o", bus.drop_o, drop);
    if (drop) check("pkt_ready after drop", bus.pkt_ready_o, 1);
    if (!feed) return;
    for (int i = 1; i < n; i++) begin
      bus.payload_valid_i = 1'b1;
      bus.payload_i = base + 32'(i) - 1;
      w = 0;
      while (!bus.payload_ready_o && w < 100) begin @(negedge clk); w++; end
      check("payload_ready", bus.payload_ready_o, 1);
      @(negedge clk);
    end
    bus.payload_valid_i = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin @(negedge clk); #1; w++; end
    check("scoreboard drained", 64'(exp_q.size()), 0);
  endtask
  task automatic return_credits(input logic vc, input int n);
    for (int i = 0; i < n; i++) begin
      bus.credit_valid_i = 1'b1;
      bus.credit_vc_i = vc;
      @(negedge clk);
    end
    bus.credit_valid_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tv[0] = '{3'd4, 3'd1, 4'd1, 1'b0, 32'h00, 1'b0, 1};
    tv[1] = '{3'd0, 3'd3, 4'd4, 1'b1, 32'hA1, 1'b0, 4};
    tv[2] = '{3'd5, 3'd2, 4'd1, 1'b0, 32'h00, 1'b1, 0};
    tv[3] = '{3'd2, 3'd2, 4'd0, 1'b1, 32'h00, 1'b0, 1};
    tv[4] = '{3'd1, 3'd4, 4'd12, 1'b0, 32'h10, 1'b0, 8};
    tv[5] = '{3'd3, 3'd0, 4'd2, 1'b1, 32'h20, 1'b0, 2};
    tv[6] = '{3'd2, 3'd5, 4'd3, 1'b1, 32'h00, 1'b1, 0};
    tv[7] = '{3'd4, 3'd4, 4'd8, 1'b1, 32'h30, 1'b0, 8};
    tv[8] = '{3'd0, 3'd0, 4'd3, 1'b0, 32'h40, 1'b0, 3};
    bus.pkt_valid_i = 1'b0;
    bus.pkt_x_dest_i = '0;
    bus.pkt_y_dest_i = '0;
    bus.pkt_len_i = '0;
    bus.pkt_vc_i = '0;
    bus.payload_valid_i = 1'b0;
    bus.payload_i = '0;
    bus.credit_valid_i = 1'b0;
    bus.credit_vc_i = '0;
    repeat (3) @(negedge clk);
    check("reset valid_flit_o", bus.valid_flit_o, 0);
    check("reset flit_o", bus.flit_o, 0);
    check("reset drop_o", bus.drop_o, 0);
    check("reset credit_err_o", bus.credit_err_o, 0);
    check("reset pkt_ready_o", bus.pkt_ready_o, 1);
    check("reset payload_ready_o", bus.payload_ready_o, 0);
    check("reset credit0", dut.credit[0], 8);
    check("reset credit1", dut.credit[1], 8);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_pkt(tv[i].x, tv[i].y, tv[i].len, tv[i].vc, tv[i].base, tv[i].exp_drop, tv[i].exp_n, 1'b1);
      check("credit after packet", dut.credit[tv[i].vc], 64'(8 - tv[i].exp_n));
      return_credits(tv[i].vc, tv[i].exp_n);
      check("credit restored", dut.credit[tv[i].vc], 8);
    end
    for (int i = 0; i < 8; i++) send_pkt(3'd1, 3'd1, 4'd1, 1'b0, 32'h0, 1'b0, 1, 1'b1);
    check("credit0 exhausted", dut.credit[0], 0);
    send_pkt(3'd2, 3'd3, 4'd1, 1'b0, 32'h0, 1'b0, 1, 1'b0);
    repeat (5) begin
      check("stall no flit", bus.valid_flit_o, 0);
      check("stall pkt_ready", bus.pkt_ready_o, 0);
      @(negedge clk);
    end
    return_credits(1'b0, 1);
    check("flit after credit return", bus.valid_flit_o, 1);
    check("credit0 after bypass send", dut.credit[0], 0);
    return_credits(1'b0, 3);
    check("credit0 at three", dut.credit[0], 3);
    send_pkt(3'd4, 3'd0, 4'd1, 1'b0, 32'h0, 1'b0, 1, 1'b0);
    bus.credit_valid_i = 1'b1;
    bus.credit_vc_i = 1'b0;
    @(negedge clk);
    bus.credit_valid_i = 1'b0;
    check("same-cycle send flit", bus.valid_flit_o, 1);
    check("same-cycle credit0", dut.credit[0], 3);
    check("same-cycle no credit_err", bus.credit_err_o, 0);
    return_credits(1'b1, 1);
    check("credit_err set", bus.credit_err_o, 1);
    check("credit1 saturated", dut.credit[1], 8);
    repeat (3) @(negedge clk);
    check("credit_err sticky", bus.credit_err_o, 1);
    send_pkt(3'd1, 3'd2, 4'd4, 1'b1, 32'hB1, 1'b0, 4, 1'b0);
    bus.payload_valid_i = 1'b1;
    bus.payload_i = 32'hB1;
    repeat (2) @(negedge clk);
    #1;
    check("second flit present", bus.valid_flit_o, 1);
    check("flits left before reset", 64'(exp_q.size()), 2);
    #1 rst = 1'b0;
    #1;
    check("reset valid_flit_o drops", bus.valid_flit_o, 0);
    check("reset payload_ready_o drops", bus.payload_ready_o, 0);
    check("reset credit0 restore", dut.credit[0], 8);
    check("reset credit1 restore", dut.credit[1], 8);
    check("reset clears credit_err", bus.credit_err_o, 0);
    exp_q.delete();
    bus.payload_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send_pkt(3'd3, 3'd3, 4'd2, 1'b1, 32'hC1, 1'b0, 2, 1'b1);
    check("credit1 after restart", dut.credit[1], 6);
    check("scoreboard empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
